// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package arb_pkg;

  typedef enum logic {IDLE, HOLD} arb_state_t;

  function automatic int rr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the arbiter: requests, locks, data, grants and register view.
interface reg_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  import arb_pkg::*;

  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           lock;
  logic [NREQ*WIDTH-1:0]     wdata;
  logic [NREQ-1:0]           gnt;
  logic [WIDTH-1:0]          q;
  logic [WIDTH-1:0]          qn;
  logic [rr_idx_w(NREQ)-1:0] owner;
  logic                      owner_valid;

  modport master (
    output req, lock, wdata,
    input  gnt, q, qn, owner, owner_valid
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, q, qn, owner, owner_valid
  );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping to 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [rr_idx_w(N)-1:0] ptr,
  output logic                   valid,
  output logic [rr_idx_w(N)-1:0] idx
);
  localparam int IW = rr_idx_w(N);

  int pos;

  // Scan from the farthest candidate back to ptr so the nearest hit is assigned last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = int'(ptr) + i;
      if (pos >= N) pos = pos - N;
      if (req[pos]) begin
        valid = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register, with bounded multi-cycle locks.
//   state | meaning
//   IDLE  | arbitrate among req from ptr each cycle; winner writes q
//   HOLD  | owner has exclusive access; others stall until release or timeout
module reg_write_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst,
  reg_write_arbiter_if.slave bus
);
  localparam int IW = rr_idx_w(NREQ);
  localparam int HW = rr_idx_w(MAX_HOLD);

  arb_state_t        state, state_nxt;
  logic [IW-1:0]     ptr, ptr_nxt;
  logic [IW-1:0]     owner, owner_nxt;
  logic [HW-1:0]     hold_left, hold_left_nxt;
  logic [IW-1:0]     pick_idx, sel;
  logic              pick_valid;
  logic              wr_en;
  logic [NREQ-1:0]   gnt;
  logic [WIDTH-1:0]  wsel;
  logic [WIDTH-1:0]  q_r, qn_r;

  rr_pick #(.N(NREQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    hold_left_nxt = hold_left;
    gnt           = '0;
    wr_en         = 1'b0;
    sel           = owner;
    case (state)
      IDLE: begin
        sel = pick_idx;
        if (pick_valid) begin
          gnt[pick_idx] = 1'b1;
          wr_en         = 1'b1;
          ptr_nxt       = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
          if (bus.lock[pick_idx]) begin
            state_nxt     = HOLD;
            owner_nxt     = pick_idx;
            hold_left_nxt = HW'(MAX_HOLD - 1);
          end
        end
      end
      HOLD: begin
        gnt[owner] = bus.req[owner];
        wr_en      = bus.req[owner];
        if (bus.req[owner]) hold_left_nxt = hold_left - HW'(1);
        // hold_left reaching zero marks the final write of this lock
        if (!bus.req[owner] || !bus.lock[owner] || hold_left == '0) begin
          state_nxt     = IDLE;
          hold_left_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wsel = bus.wdata[sel*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      hold_left <= '0;
      q_r       <= '0;
      qn_r      <= '1;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      hold_left <= hold_left_nxt;
      if (wr_en) begin
        q_r  <= wsel;
        qn_r <= ~wsel;
      end
    end
  end

  // No writes can land while reset is held, so grants are suppressed too.
  assign bus.gnt         = rst ? '0 : gnt;
  assign bus.q           = q_r;
  assign bus.qn          = qn_r;
  assign bus.owner       = owner;
  assign bus.owner_valid = (state == HOLD);

  gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));

endmodule
